// File: rtl/bcd_pkg.sv
// Shared BCD digit type, terminal digit constant and validity check for bcd_counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic logic is_valid_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: counts 0..9 when inc_in is high and flags the ripple to the next decade.
module bcd_digit
  import bcd_pkg::*;
#(
  parameter bcd_digit_t RESET_VALUE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_asyn,
  input  logic       inc_in,
  output bcd_digit_t value,
  output logic       carry
);

  // Illegal codes recover to 0 on the next edge, whether or not this decade is stepping.
  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      value <= RESET_VALUE;
    end else if (!is_valid_bcd(value)) begin
      value <= 4'd0;
    end else if (inc_in) begin
      value <= (value == BCD_MAX) ? 4'd0 : 4'(value + 4'd1);
    end
  end

  assign carry = inc_in & (value == BCD_MAX);

endmodule

// File: rtl/bcd_counter.sv
// Cascaded BCD up-counter with async active-low reset and a synchronised release.
// Optional count enable port when BCD_COUNTER_CNT_ENABLE_EN is defined.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int unsigned                 NUM_DIGITS  = 1,
  parameter logic [4*NUM_DIGITS-1:0]     RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_asyn,
`ifdef BCD_COUNTER_CNT_ENABLE_EN
  input  logic                    cnt_en,
`endif
  output logic [4*NUM_DIGITS-1:0] Q_out,
  output logic                    carry_out
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  function automatic logic [W-1:0] legal_reset(input logic [W-1:0] v);
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (!is_valid_bcd(v[4*i +: 4])) return '0;
    end
    return v;
  endfunction

  localparam logic [W-1:0] RST_VAL = legal_reset(RESET_VALUE);

  logic [1:0]            sync_q;
  logic                  run;
  logic                  en;
  logic [NUM_DIGITS:0]   inc;
  logic [NUM_DIGITS-1:0] nine;
  logic                  chain_unused;

  // Release synchroniser: counting starts once the first stage has captured the release.
  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run = |sync_q;

`ifdef BCD_COUNTER_CNT_ENABLE_EN
  assign en = cnt_en;
`else
  assign en = 1'b1;
`endif

  assign inc[0] = run & en;

  for (genvar k = 0; k < int'(NUM_DIGITS); k++) begin : g_digit
    bcd_digit #(
      .RESET_VALUE (RST_VAL[4*k +: 4])
    ) u_digit (
      .clk      (clk),
      .rst_asyn (rst_asyn),
      .inc_in   (inc[k]),
      .value    (Q_out[4*k +: 4]),
      .carry    (inc[k+1])
    );
    assign nine[k] = (Q_out[4*k +: 4] == BCD_MAX);
  end

  // Terminal count is decoded from state so it also reflects the reset value.
  assign chain_unused = inc[NUM_DIGITS];
  assign carry_out    = en & (&nine);

endmodule

// File: tb/tb_bcd_counter.sv
// Directed self-checking bench for bcd_counter: 1-digit and 2-digit instances.
`timescale 1ns/1ps
module tb_bcd_counter;

  logic       clk = 1'b0;
  logic       rst1;
  logic       rst2;
  logic [3:0] q1;
  logic [7:0] q2;
  logic       carry1;
  logic       carry2;
  logic       cnt_en1;
  logic       cnt_en2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_counter #(.NUM_DIGITS(1)) dut1 (
    .clk       (clk),
    .rst_asyn  (rst1),
`ifdef BCD_COUNTER_CNT_ENABLE_EN
    .cnt_en    (cnt_en1),
`endif
    .Q_out     (q1),
    .carry_out (carry1)
  );

  bcd_counter #(.NUM_DIGITS(2)) dut2 (
    .clk       (clk),
    .rst_asyn  (rst2),
`ifdef BCD_COUNTER_CNT_ENABLE_EN
    .cnt_en    (cnt_en2),
`endif
    .Q_out     (q2),
    .carry_out (carry2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b0;
    rst2 = 1'b0;
    #1;
    checks++;
    if (q1 !== 4'd0 || carry1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial q1=%h carry1=%b exp q1=0 carry1=0", q1, carry1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q1 !== 4'd0 || carry1 !== 1'b0 || q2 !== 8'h00 || carry2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d] q1=%h c1=%b q2=%h c2=%b exp all 0", i, q1, carry1, q2, carry2);
      end
    end
  endtask

  task automatic test_count_wrap();
    rst1 = 1'b1;
    rst2 = 1'b1;
    tick();
    checks++;
    if (q1 !== 4'd0) begin
      failures++;
      $display("FAIL release_first_edge q1=%h exp 0", q1);
    end
    for (int i = 1; i <= 12; i++) begin
      logic [3:0] exp_q;
      exp_q = 4'(i % 10);
      tick();
      checks++;
      if (q1 !== exp_q || carry1 !== (exp_q == 4'd9)) begin
        failures++;
        $display("FAIL count_wrap[%0d] q1=%h carry1=%b exp q1=%h carry1=%b",
                 i, q1, carry1, exp_q, (exp_q == 4'd9));
      end
    end
  endtask

  task automatic test_async_reset();
    tick();
    tick();
    checks++;
    if (q1 !== 4'd4) begin
      failures++;
      $display("FAIL pre_async q1=%h exp 4", q1);
    end
    #2;
    rst1 = 1'b0;
    #0.5;
    checks++;
    if (q1 !== 4'd0 || carry1 !== 1'b0) begin
      failures++;
      $display("FAIL async_clear q1=%h carry1=%b exp q1=0 carry1=0", q1, carry1);
    end
    #0.5;
    rst1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q1 !== 4'(i)) begin
        failures++;
        $display("FAIL async_resume[%0d] q1=%h exp %h", i, q1, 4'(i));
      end
    end
  endtask

`ifdef BCD_COUNTER_CNT_ENABLE_EN
  task automatic test_enable();
    tick();
    checks++;
    if (q1 !== 4'd3) begin
      failures++;
      $display("FAIL enable_start q1=%h exp 3", q1);
    end
    cnt_en1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (q1 !== 4'd3 || carry1 !== 1'b0) begin
        failures++;
        $display("FAIL enable_hold[%0d] q1=%h carry1=%b exp q1=3 carry1=0", i, q1, carry1);
      end
    end
    cnt_en1 = 1'b1;
    tick();
    checks++;
    if (q1 !== 4'd4) begin
      failures++;
      $display("FAIL enable_resume q1=%h exp 4", q1);
    end
  endtask
`endif

  task automatic test_multi_digit();
    rst2 = 1'b0;
    #1;
    checks++;
    if (q2 !== 8'h00) begin
      failures++;
      $display("FAIL multi_async_clear q2=%h exp 00", q2);
    end
    #1;
    rst2 = 1'b1;
    tick();
    checks++;
    if (q2 !== 8'h00) begin
      failures++;
      $display("FAIL multi_first_edge q2=%h exp 00", q2);
    end
    for (int i = 1; i <= 125; i++) begin
      int         v;
      logic [7:0] exp_q;
      v     = i % 100;
      exp_q = {4'(v / 10), 4'(v % 10)};
      tick();
      checks++;
      if (q2 !== exp_q || carry2 !== (v == 99)) begin
        failures++;
        $display("FAIL multi_count[%0d] q2=%h carry2=%b exp q2=%h carry2=%b",
                 i, q2, carry2, exp_q, (v == 99));
      end
    end
  endtask

  task automatic test_illegal();
    force dut2.g_digit[0].u_digit.value = 4'hC;
    #1;
    checks++;
    if (q2 !== 8'h2C) begin
      failures++;
      $display("FAIL illegal_forced q2=%h exp 2c", q2);
    end
    release dut2.g_digit[0].u_digit.value;
    tick();
    checks++;
    if (q2 !== 8'h20 || carry2 !== 1'b0) begin
      failures++;
      $display("FAIL illegal_recover q2=%h carry2=%b exp q2=20 carry2=0", q2, carry2);
    end
    tick();
    checks++;
    if (q2 !== 8'h21) begin
      failures++;
      $display("FAIL illegal_next q2=%h exp 21", q2);
    end
  endtask

  initial begin
    cnt_en1 = 1'b1;
    cnt_en2 = 1'b1;
    test_reset();
    test_count_wrap();
    test_async_reset();
`ifdef BCD_COUNTER_CNT_ENABLE_EN
    test_enable();
`endif
    test_multi_digit();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
